lsu_mem_access: RTL and testbench

//  Multi-cycle load/store unit directly downstream of the register file.

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_wait_timer.sv | 39 +++
 rtl/lsu_mem_access.sv | 140 ++++++++++++++
 tb/tb_lsu_mem_access.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared state encoding and default sizing for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } lsu_state_t;

  localparam int LSU_DW      = 8;
  localparam int LSU_AW      = 8;
  localparam int LSU_RW      = 4;
  localparam int LSU_TIMEOUT = 15;

endpackage

// File: rtl/lsu_wait_timer.sv
// Counts REQ cycles without an acknowledge and flags when the wait budget is used up.
module lsu_wait_timer
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = LSU_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Expiry is seen in the cycle whose missing ack would bring the count to TIMEOUT.
  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Multi-cycle load/store unit between register file and data memory (req/ack handshake).
// Optional REQ wait timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int DW = LSU_DW,
  parameter int AW = LSU_AW,
  parameter int RW = LSU_RW
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT = LSU_TIMEOUT
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          is_store,
  input  logic [RW-1:0] rd_dest,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] st_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          rf_wr_en,
  output logic [RW-1:0] rf_wr_addr,
  output logic [DW-1:0] rf_dat
);

  lsu_state_t    state_q;
  logic          is_store_q;
  logic [RW-1:0] rd_dest_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          done_q;
  logic          rf_wr_en_q;
  logic [RW-1:0] rf_wr_addr_q;
  logic [DW-1:0] rf_dat_q;

`ifdef LSU_TIMEOUT_EN
  logic err_q;
  logic expired;

  lsu_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_q == IDLE && start),
    .inc_i    (state_q == REQ && !mem_ack),
    .expired_o(expired)
  );

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_dat     = rf_dat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      rd_dest_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      done_q       <= 1'b0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_dat_q     <= '0;
`ifdef LSU_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      rf_wr_en_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            is_store_q  <= is_store;
            rd_dest_q   <= rd_dest;
            mem_addr_q  <= addr;
            mem_wdata_q <= st_data;
            mem_req_q   <= 1'b1;
            mem_we_q    <= is_store;
            state_q     <= REQ;
          end
        end
        REQ: begin
          // An ack always wins over a timeout landing in the same cycle.
          if (mem_ack) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            done_q     <= 1'b1;
            rf_wr_en_q <= !is_store_q;
            if (!is_store_q) begin
              rf_wr_addr_q <= rd_dest_q;
              rf_dat_q     <= mem_rdata;
            end
            state_q <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (expired) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= ERR;
          end
`endif
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
`timescale 1ns/1ps
module tb_lsu_mem_access;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       is_store = 1'b0;
    logic [3:0] rd_dest = '0;
    logic [7:0] addr = '0;
    logic [7:0] st_data = '0;
    logic [7:0] mem_rdata = '0;
    logic       mem_ack = 1'b0;
    logic       busy, done, err, mem_req, mem_we, rf_wr_en;
    logic [7:0] mem_addr, mem_wdata, rf_dat;
    logic [3:0] rf_wr_addr;

    int checks = 0;
    int errors = 0;
    int done_cnt;

    always #5 clk = ~clk;

    lsu_mem_access dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_store  (is_store),
        .rd_dest   (rd_dest),
        .addr      (addr),
        .st_data   (st_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .rf_wr_en  (rf_wr_en),
        .rf_wr_addr(rf_wr_addr),
        .rf_dat    (rf_dat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            $display("PASS %s: %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_wdata", mem_wdata, 8'h00);
        chk("rst_rfwe", rf_wr_en, 1'b0);
        chk("rst_rfaddr", rf_wr_addr, 4'h0);
        chk("rst_rfdat", rf_dat, 8'h00);
        reset = 1'b0;
        step();

        start = 1'b1; is_store = 1'b0; addr = 8'h10; rd_dest = 4'd3;
        step();
        start = 1'b0;
        chk("ld_c1_req", mem_req, 1'b1);
        chk("ld_c1_we", mem_we, 1'b0);
        chk("ld_c1_addr", mem_addr, 8'h10);
        chk("ld_c1_busy", busy, 1'b1);
        mem_ack = 1'b1; mem_rdata = 8'hA5;
        step();
        mem_ack = 1'b0;
        chk("ld_c2_done", done, 1'b1);
        chk("ld_c2_rfwe", rf_wr_en, 1'b1);
        chk("ld_c2_rfaddr", rf_wr_addr, 4'd3);
        chk("ld_c2_rfdat", rf_dat, 8'hA5);
        chk("ld_c2_req", mem_req, 1'b0);
        step();
        chk("ld_c3_done", done, 1'b0);
        chk("ld_c3_rfwe", rf_wr_en, 1'b0);
        chk("ld_c3_busy", busy, 1'b0);

        start = 1'b1; is_store = 1'b1; addr = 8'h20; st_data = 8'h5C;
        step();
        start = 1'b0; st_data = 8'hFF; addr = 8'hEE;
        for (int c = 1; c <= 4; c++) begin
            chk("st_req", mem_req, 1'b1);
            chk("st_we", mem_we, 1'b1);
            chk("st_wdata", mem_wdata, 8'h5C);
            chk("st_addr", mem_addr, 8'h20);
            chk("st_done_early", done, 1'b0);
            if (c == 4) mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
        chk("st_c5_done", done, 1'b1);
        chk("st_c5_rfwe", rf_wr_en, 1'b0);
        chk("st_c5_req", mem_req, 1'b0);
        step();
        chk("st_c6_done", done, 1'b0);
        chk("st_c6_busy", busy, 1'b0);

        start = 1'b1; is_store = 1'b0; addr = 8'h30; rd_dest = 4'd7;
        step();
        chk("bb_c1_addr", mem_addr, 8'h30);
        addr = 8'h40; rd_dest = 4'd9;
        mem_ack = 1'b1; mem_rdata = 8'h11;
        step();
        chk("bb_c2_done", done, 1'b1);
        chk("bb_c2_rfaddr", rf_wr_addr, 4'd7);
        chk("bb_c2_rfdat", rf_dat, 8'h11);
        mem_rdata = 8'h22;
        step();
        chk("bb_c3_busy", busy, 1'b0);
        chk("bb_c3_done", done, 1'b0);
        chk("bb_c3_rfwe", rf_wr_en, 1'b0);
        step();
        start = 1'b0;
        chk("bb_c4_req", mem_req, 1'b1);
        chk("bb_c4_addr", mem_addr, 8'h40);
        chk("bb_c4_done", done, 1'b0);
        step();
        mem_ack = 1'b0;
        chk("bb_c5_done", done, 1'b1);
        chk("bb_c5_rfaddr", rf_wr_addr, 4'd9);
        chk("bb_c5_rfdat", rf_dat, 8'h22);
        step();
        chk("bb_c6_done", done, 1'b0);

        start = 1'b1; is_store = 1'b0; addr = 8'h50; rd_dest = 4'd4;
        step();
        start = 1'b0;
        chk("rr_req_before", mem_req, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("rr_req_async", mem_req, 1'b0);
        chk("rr_busy_async", busy, 1'b0);
        chk("rr_rfwe_async", rf_wr_en, 1'b0);
        mem_ack = 1'b1; mem_rdata = 8'h77;
        step();
        chk("rr_rfwe_hold", rf_wr_en, 1'b0);
        chk("rr_done_hold", done, 1'b0);
        reset = 1'b0;
        step();
        chk("rr_idle_ack_ign", done, 1'b0);
        mem_ack = 1'b0;
        start = 1'b1; addr = 8'h55; rd_dest = 4'd2;
        step();
        start = 1'b0;
        chk("rr_new_addr", mem_addr, 8'h55);
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        step();
        mem_ack = 1'b0;
        chk("rr_new_done", done, 1'b1);
        chk("rr_new_rfaddr", rf_wr_addr, 4'd2);
        chk("rr_new_rfdat", rf_dat, 8'h3C);
        step();

`ifdef LSU_TIMEOUT_EN
        start = 1'b1; addr = 8'h60; rd_dest = 4'd5;
        step();
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            chk("to_req", mem_req, 1'b1);
            chk("to_done_early", done, 1'b0);
            step();
        end
        chk("to_done", done, 1'b1);
        chk("to_err", err, 1'b1);
        chk("to_req_low", mem_req, 1'b0);
        chk("to_rfwe", rf_wr_en, 1'b0);
        step();
        chk("to_after_done", done, 1'b0);
        chk("to_after_err", err, 1'b0);
        chk("to_after_busy", busy, 1'b0);

        start = 1'b1; addr = 8'h61; rd_dest = 4'd6;
        step();
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            chk("tb_req", mem_req, 1'b1);
            if (c == 15) begin
                mem_ack = 1'b1; mem_rdata = 8'h99;
            end
            step();
        end
        mem_ack = 1'b0;
        chk("tb_done", done, 1'b1);
        chk("tb_err", err, 1'b0);
        chk("tb_rfwe", rf_wr_en, 1'b1);
        chk("tb_rfdat", rf_dat, 8'h99);
        step();
`else
        start = 1'b1; addr = 8'h60; rd_dest = 4'd5;
        step();
        start = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (done || err) done_cnt++;
            step();
        end
        chk("nt_req_held", mem_req, 1'b1);
        chk("nt_busy", busy, 1'b1);
        chk("nt_no_done", done_cnt, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
